// File: rtl/ring_counter_param.sv
// WIDTH-bit ring (one-hot) / Johnson shift counter with load, one-hot preset and wrap pulse.
// Optional RING_COUNTER_SELF_CORRECT_EN: an enabled shift from an illegal state restores the base state.
module ring_counter_param #(
    parameter int unsigned WIDTH     = 4,
    parameter logic [31:0] RESET_VAL = 32'd1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        mode,
    input  logic                                        dir,
    input  logic                                        load,
    input  logic [WIDTH-1:0]                            load_val,
    input  logic                                        set_pos,
    input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] pos,
    output logic [WIDTH-1:0]                            out,
    output logic                                        wrap,
    output logic                                        illegal
);

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic             r_illegal;

    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_onehot;
    logic             w_pos_ok;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;
    logic             w_ill_next;

    // Ring legality: exactly one bit set.
    function automatic logic f_ring_illegal(input logic [WIDTH-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + {31'd0, v[i]};
        end
        return ones != 32'd1;
    endfunction

    // Johnson legality: at most one boundary between adjacent bits.
    function automatic logic f_johnson_illegal(input logic [WIDTH-1:0] v);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            if (v[i] != v[i+1]) begin
                edges = edges + 32'd1;
            end
        end
        return edges > 32'd1;
    endfunction

    function automatic logic f_illegal(input logic [WIDTH-1:0] v, input logic johnson);
        return johnson ? f_johnson_illegal(v) : f_ring_illegal(v);
    endfunction

    always_comb begin
        w_shift = r_out;
        if (!dir) begin
            w_shift = {r_out[WIDTH-2:0], mode ? ~r_out[WIDTH-1] : r_out[WIDTH-1]};
        end else begin
            w_shift = {mode ? ~r_out[0] : r_out[0], r_out[WIDTH-1:1]};
        end
    end

    // Base state is 1 in ring mode and all zeros in Johnson mode.
    assign w_base   = {{(WIDTH-1){1'b0}}, ~mode};
    assign w_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << pos;
    assign w_pos_ok = (32'(pos) < WIDTH);

`ifdef RING_COUNTER_SELF_CORRECT_EN
    logic w_cur_illegal;
    assign w_cur_illegal = f_illegal(r_out, mode);
`endif

    always_comb begin
        w_next      = r_out;
        w_wrap_next = 1'b0;
        if (load) begin
            w_next = load_val;
        end else if (set_pos) begin
            w_next = w_pos_ok ? w_onehot : r_out;
        end else if (en) begin
`ifdef RING_COUNTER_SELF_CORRECT_EN
            if (w_cur_illegal) begin
                w_next      = w_base;
                w_wrap_next = 1'b1;
            end else begin
                w_next      = w_shift;
                w_wrap_next = (w_shift == w_base);
            end
`else
            w_next      = w_shift;
            w_wrap_next = (w_shift == w_base);
`endif
        end
    end

    assign w_ill_next = f_illegal(w_next, mode);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out     <= RESET_VAL[WIDTH-1:0];
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_out     <= w_next;
            r_wrap    <= w_wrap_next;
            r_illegal <= w_ill_next;
        end
    end

    assign out     = r_out;
    assign wrap    = r_wrap;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_ring_counter_param.sv
// Self-checking bench for ring_counter_param: directed pins plus randomized run vs. a model.
module tb_ring_counter_param;

    localparam int W = 4;

    logic         clk;
    logic         rst, en, mode, dir, load, set_pos;
    logic [W-1:0] load_val;
    logic [1:0]   pos;
    logic [W-1:0] out;
    logic         wrap, illegal;

    logic         set_pos6;
    logic [2:0]   pos6;
    logic [5:0]   out6;
    logic         wrap6, illegal6;

    int n_checks;
    int n_errors;
    bit chk_en;

    logic [W-1:0] m_out;
    logic         m_wrap, m_ill;

    ring_counter_param #(.WIDTH(W), .RESET_VAL(32'd1)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .set_pos(set_pos), .pos(pos),
        .out(out), .wrap(wrap), .illegal(illegal)
    );

    ring_counter_param #(.WIDTH(6), .RESET_VAL(32'd1)) dut6 (
        .clk(clk), .rst(rst), .en(1'b0), .mode(1'b0), .dir(1'b0), .load(1'b0),
        .load_val(6'd0), .set_pos(set_pos6), .pos(pos6),
        .out(out6), .wrap(wrap6), .illegal(illegal6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_illegal(input int v, input logic johnson);
        if (!johnson) return $countones(v) != 1;
        return $countones((v ^ (v >> 1)) & ((1 << (W - 1)) - 1)) > 1;
    endfunction

    function automatic int model_shift(input int v, input logic johnson, input logic down);
        int in_bit;
        int mask;
        mask = (1 << W) - 1;
        if (!down) begin
            in_bit = (v >> (W - 1)) & 1;
            if (johnson) in_bit = 1 - in_bit;
            return ((v << 1) | in_bit) & mask;
        end
        in_bit = v & 1;
        if (johnson) in_bit = 1 - in_bit;
        return (v >> 1) | (in_bit << (W - 1));
    endfunction

    // Returns {illegal, wrap, out} expected after the coming edge.
    function automatic logic [W+1:0] model_next(input logic [W-1:0] cur, input logic r,
        input logic e, input logic m, input logic d, input logic l, input logic [W-1:0] lv,
        input logic s, input logic [1:0] p);
        int   v, nv, base;
        logic wr;
        v    = int'(cur);
        base = m ? 0 : 1;
        wr   = 1'b0;
        if (!r) return {1'b0, 1'b0, 4'b0001};
        if (l) begin
            nv = int'(lv);
        end else if (s) begin
            nv = 1 << p;
        end else if (e) begin
`ifdef RING_COUNTER_SELF_CORRECT_EN
            if (model_illegal(v, m)) begin
                nv = base;
                wr = 1'b1;
            end else begin
                nv = model_shift(v, m, d);
                wr = (nv == base);
            end
`else
            nv = model_shift(v, m, d);
            wr = (nv == base);
`endif
        end else begin
            nv = v;
        end
        return {model_illegal(nv, m), wr, nv[W-1:0]};
    endfunction

    always @(posedge clk) begin
        {m_ill, m_wrap, m_out} <= model_next(m_out, rst, en, mode, dir, load, load_val,
                                             set_pos, pos);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (out !== m_out || wrap !== m_wrap || illegal !== m_ill) begin
                n_errors++;
                $display("FAIL model t=%0t out=%b wrap=%b illegal=%b expected out=%b wrap=%b illegal=%b",
                         $time, out, wrap, illegal, m_out, m_wrap, m_ill);
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic m, input logic d,
                       input logic l, input logic [W-1:0] lv, input logic s, input logic [1:0] p);
        rst = r; en = e; mode = m; dir = d; load = l; load_val = lv; set_pos = s; pos = p;
        @(negedge clk);
    endtask

    task automatic pin(input string nm, input logic [W-1:0] eo, input logic ew, input logic ei);
        n_checks++;
        if (out !== eo || wrap !== ew || illegal !== ei) begin
            n_errors++;
            $display("FAIL %s out=%b wrap=%b illegal=%b expected out=%b wrap=%b illegal=%b",
                     nm, out, wrap, illegal, eo, ew, ei);
        end
    endtask

    task automatic pin6(input string nm, input logic [5:0] eo);
        n_checks++;
        if (out6 !== eo) begin
            n_errors++;
            $display("FAIL %s out=%b expected out=%b", nm, out6, eo);
        end
    endtask

    logic [W-1:0] john_seq [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        set_pos6 = 1'b0;
        pos6     = 3'd0;
        john_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0;
        load_val = '0; set_pos = 1'b0; pos = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        pin("reset", 4'b0001, 1'b0, 1'b0);

        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("ring_up1", 4'b0010, 0, 0);
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("ring_up2", 4'b0100, 0, 0);
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("ring_up3", 4'b1000, 0, 0);
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("ring_up_wrap", 4'b0001, 1, 0);

        cyc(1, 1, 0, 1, 0, 4'h0, 0, 0); pin("ring_dn1", 4'b1000, 0, 0);
        cyc(1, 1, 0, 1, 0, 4'h0, 0, 0); pin("ring_dn2", 4'b0100, 0, 0);
        cyc(1, 1, 0, 1, 0, 4'h0, 1, 3); pin("set_pos3", 4'b1000, 0, 0);
        cyc(1, 1, 0, 1, 0, 4'h0, 0, 0); pin("ring_dn3", 4'b0100, 0, 0);
        cyc(1, 1, 0, 1, 0, 4'h0, 0, 0); pin("ring_dn4", 4'b0010, 0, 0);
        cyc(1, 1, 0, 1, 0, 4'h0, 0, 0); pin("ring_dn_wrap", 4'b0001, 1, 0);

        cyc(1, 0, 1, 0, 1, 4'b0000, 0, 0); pin("john_load0", 4'b0000, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 1, 0, 0, 4'h0, 0, 0);
            pin("john_seq", john_seq[i], (i == 7), 1'b0);
        end

        cyc(1, 0, 0, 0, 1, 4'b0101, 0, 0); pin("load_illegal", 4'b0101, 0, 1);
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0);
`ifdef RING_COUNTER_SELF_CORRECT_EN
        pin("shift_illegal", 4'b0001, 1, 0);
`else
        pin("shift_illegal", 4'b1010, 0, 1);
`endif

        cyc(1, 1, 0, 0, 1, 4'b0100, 1, 0); pin("load_wins", 4'b0100, 0, 0);
        cyc(0, 1, 0, 0, 1, 4'b1111, 0, 0); pin("rst_over_load", 4'b0001, 0, 0);

        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("run1", 4'b0010, 0, 0);
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("run2", 4'b0100, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 4'h0, 0, 0); pin("hold", 4'b0100, 0, 0);
        end
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("resume", 4'b1000, 0, 0);
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("resume_wrap", 4'b0001, 1, 0);
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("run3", 4'b0010, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'h0, 0, 0); pin("mid_reset", 4'b0001, 0, 0);
        cyc(1, 1, 0, 0, 0, 4'h0, 0, 0); pin("after_reset", 4'b0010, 0, 0);

        set_pos6 = 1'b1; pos6 = 3'd2;
        cyc(1, 0, 0, 0, 0, 4'h0, 0, 0); pin6("w6_pos2", 6'b000100);
        pos6 = 3'd7;
        cyc(1, 0, 0, 0, 0, 4'h0, 0, 0); pin6("w6_pos7_hold", 6'b000100);
        pos6 = 3'd5;
        cyc(1, 0, 0, 0, 0, 4'h0, 0, 0); pin6("w6_pos5", 6'b100000);
        set_pos6 = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                ($urandom_range(0, 7) == 0) ? ~mode : mode,
                ($urandom_range(0, 7) == 0) ? ~dir : dir,
                $urandom_range(0, 11) == 0, 4'($urandom),
                $urandom_range(0, 11) == 0, 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
